// File: rtl/alu_bist.sv
// alu_bist: LFSR-driven self-test sequencer for the datapath ALU.
// Define ALU_BIST_MISR_EN to build the MISR result signature.
module alu_bist #(
    parameter int unsigned VECTORS_PER_OP = 32,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_2468,
    parameter logic [31:0] OPERAND_MASK   = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [31:0] o_alu_op1,
    output logic [31:0] o_alu_op2,
    output logic [3:0]  o_alu_control,
    input  logic [31:0] i_alu_result,
    input  logic        i_alu_zf,
    output logic [3:0]  o_fail_op,
    output logic [7:0]  o_fail_idx,
    output logic [32:0] o_fail_expected,
    output logic [32:0] o_fail_actual,
    output logic [31:0] o_signature
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SOLT = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    localparam logic [31:0] SEED     = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    localparam logic [7:0]  LAST_IDX = 8'(VECTORS_PER_OP - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] lfsr;
    logic [2:0]  op_sel;
    logic [2:0]  op_nx;
    logic [7:0]  idx;
    logic [7:0]  idx_nx;
    logic        wrap;
    logic        last_vec;
    logic        start_ok;
    logic [31:0] exp_res;
    logic [32:0] expected;
    logic [32:0] actual;
    logic        mismatch;

    function automatic logic [31:0] step(input logic [31:0] s);
        step = {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [3:0] op_code(input logic [2:0] k);
        case (k)
            3'd0:    op_code = ALU_AND;
            3'd1:    op_code = ALU_OR;
            3'd2:    op_code = ALU_ADD;
            3'd3:    op_code = ALU_SUB;
            3'd4:    op_code = ALU_SOLT;
            default: op_code = ALU_NOR;
        endcase
    endfunction

    assign start_ok = i_start && (state == IDLE || state == DONE);
    assign wrap     = (idx == LAST_IDX);
    assign idx_nx   = wrap ? 8'd0 : idx + 8'd1;
    assign op_nx    = wrap ? op_sel + 3'd1 : op_sel;
    assign last_vec = wrap && (op_sel == 3'd5);
    assign o_busy   = (state == DRIVE) || (state == CHECK);
    assign o_done   = (state == DONE);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state: one settle cycle, one compare cycle per vector
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: if (i_start) state_nx = DRIVE;
            DRIVE:      state_nx = CHECK;
            CHECK:      state_nx = last_vec ? DONE : DRIVE;
            default:    state_nx = IDLE;
        endcase
    end

    // Vector generation: LFSR pair per vector, op/index sweep, drive registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr          <= 32'h0;
            op_sel        <= 3'd0;
            idx           <= 8'd0;
            o_alu_op1     <= 32'h0;
            o_alu_op2     <= 32'h0;
            o_alu_control <= 4'h0;
        end else if (start_ok) begin
            lfsr          <= step(step(SEED));
            op_sel        <= 3'd0;
            idx           <= 8'd0;
            o_alu_op1     <= SEED & OPERAND_MASK;
            o_alu_op2     <= step(SEED) & OPERAND_MASK;
            o_alu_control <= ALU_AND;
        end else if (state == CHECK && !last_vec) begin
            lfsr          <= step(step(lfsr));
            op_sel        <= op_nx;
            idx           <= idx_nx;
            o_alu_op1     <= lfsr & OPERAND_MASK;
            o_alu_op2     <= step(lfsr) & OPERAND_MASK;
            o_alu_control <= op_code(op_nx);
        end
    end

    // Golden ALU model on the currently driven vector
    always_comb begin
        exp_res = 32'h0;
        case (o_alu_control)
            ALU_AND:  exp_res = o_alu_op1 & o_alu_op2;
            ALU_OR:   exp_res = o_alu_op1 | o_alu_op2;
            ALU_ADD:  exp_res = o_alu_op1 + o_alu_op2;
            ALU_SUB:  exp_res = o_alu_op1 - o_alu_op2;
            ALU_SOLT: exp_res = {31'h0, $signed(o_alu_op1) < $signed(o_alu_op2)};
            ALU_NOR:  exp_res = ~(o_alu_op1 | o_alu_op2);
            default:  exp_res = 32'h0;
        endcase
    end

    assign expected = {exp_res == 32'h0, exp_res};
    assign actual   = {i_alu_zf, i_alu_result};
    assign mismatch = (expected != actual);

    // Pass flag and first-failure capture; o_pass doubles as "no fail yet"
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pass          <= 1'b0;
            o_fail_op       <= 4'h0;
            o_fail_idx      <= 8'h0;
            o_fail_expected <= 33'h0;
            o_fail_actual   <= 33'h0;
        end else if (start_ok) begin
            o_pass          <= 1'b1;
            o_fail_op       <= 4'h0;
            o_fail_idx      <= 8'h0;
            o_fail_expected <= 33'h0;
            o_fail_actual   <= 33'h0;
        end else if (state == CHECK && mismatch && o_pass) begin
            o_pass          <= 1'b0;
            o_fail_op       <= o_alu_control;
            o_fail_idx      <= idx;
            o_fail_expected <= expected;
            o_fail_actual   <= actual;
        end
    end

`ifdef ALU_BIST_MISR_EN
    logic [31:0] misr;

    // MISR folds every sampled result into the signature
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            misr <= 32'h0;
        else if (start_ok)
            misr <= 32'h0;
        else if (state == CHECK)
            misr <= step(misr) ^ i_alu_result ^ {31'h0, i_alu_zf};
    end

    assign o_signature = misr;
`else
    assign o_signature = 32'h0;
`endif

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: directed runs of alu_bist against a bench ALU with
// injectable faults, checked every cycle against a vector-level model.
module tb_alu_bist;

    localparam int VPO = 32;
    localparam int NV  = 6 * VPO;
    localparam int RUN = 2 * NV;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SOLT = 4'b0111;
    localparam logic [3:0] C_NOR  = 4'b1100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass, alu_zf;
    logic [31:0] op1, op2, alu_result, sig;
    logic [3:0]  ctl, fop;
    logic [7:0]  fidx;
    logic [32:0] fexp, fact;

    alu_bist dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_busy(busy), .o_done(done), .o_pass(pass),
        .o_alu_op1(op1), .o_alu_op2(op2), .o_alu_control(ctl),
        .i_alu_result(alu_result), .i_alu_zf(alu_zf),
        .o_fail_op(fop), .o_fail_idx(fidx),
        .o_fail_expected(fexp), .o_fail_actual(fact),
        .o_signature(sig)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int fault_mode = 0;
    int cyc = 0;
    int t0 = 0;
    bit track = 0;
    bit hold = 0;
    bit zchk = 0;
    int post = 0;
    int bcnt = 0;
    logic [31:0] good_sig = 32'h0;

    logic [31:0] m_op1 [NV];
    logic [31:0] m_op2 [NV];
    logic [3:0]  m_ctl [NV];
    logic [31:0] m_sig [NV+1];
    int          m_fail;
    logic [32:0] m_fexp, m_fact;

    function automatic logic [31:0] step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [3:0] code_of(input int k);
        case (k)
            0: return C_AND;
            1: return C_OR;
            2: return C_ADD;
            3: return C_SUB;
            4: return C_SOLT;
            default: return C_NOR;
        endcase
    endfunction

    // fm: 0 correct, 1 ADD bit 0 flipped, 2 SOLT compares unsigned
    function automatic logic [32:0] bench_alu(input logic [3:0] c,
        input logic [31:0] a, input logic [31:0] b, input int fm);
        logic [31:0] r;
        case (c)
            C_AND:  r = a & b;
            C_OR:   r = a | b;
            C_ADD:  r = a + b;
            C_SUB:  r = a - b;
            C_SOLT: r = (fm == 2) ? {31'h0, a < b}
                                  : {31'h0, $signed(a) < $signed(b)};
            C_NOR:  r = ~(a | b);
            default: r = 32'h0;
        endcase
        if (fm == 1 && c == C_ADD) r[0] = ~r[0];
        return {r == 32'h0, r};
    endfunction

    assign {alu_zf, alu_result} = bench_alu(ctl, op1, op2, fault_mode);

    task automatic build_model();
        logic [31:0] l;
        logic [32:0] g, a;
        l = 32'hACE1_2468;
        m_fail = -1;
        m_fexp = 33'h0;
        m_fact = 33'h0;
        m_sig[0] = 32'h0;
        for (int v = 0; v < NV; v++) begin
            m_op1[v] = l;
            m_op2[v] = step(l);
            l = step(step(l));
            m_ctl[v] = code_of(v / VPO);
            g = bench_alu(m_ctl[v], m_op1[v], m_op2[v], 0);
            a = bench_alu(m_ctl[v], m_op1[v], m_op2[v], fault_mode);
            if (m_fail < 0 && g != a) begin
                m_fail = v;
                m_fexp = g;
                m_fact = a;
            end
            m_sig[v+1] = step(m_sig[v]) ^ a[31:0] ^ {31'h0, a[32]};
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_busy"}, 64'(busy), 64'd0);
        chk({t, "_done"}, 64'(done), 64'd0);
        chk({t, "_pass"}, 64'(pass), 64'd0);
        chk({t, "_op1"}, 64'(op1), 64'd0);
        chk({t, "_op2"}, 64'(op2), 64'd0);
        chk({t, "_ctl"}, 64'(ctl), 64'd0);
        chk({t, "_fop"}, 64'(fop), 64'd0);
        chk({t, "_fidx"}, 64'(fidx), 64'd0);
        chk({t, "_fexp"}, 64'(fexp), 64'd0);
        chk({t, "_fact"}, 64'(fact), 64'd0);
        chk({t, "_sig"}, 64'(sig), 64'd0);
    endtask

    // Expected outputs after edge e of a run, from the vector list
    task automatic check_cycle();
        int e, le, v, nc;
        bit bx, fx;
        logic [31:0] sx;
        e = cyc - t0 - 1;
        if (e < 0) return;
        le = (hold && e > RUN) ? e - RUN - 1 : e;
        bx = le < RUN;
        v  = bx ? le / 2 : NV - 1;
        nc = bx ? le / 2 : NV;
        fx = (m_fail >= 0) && (nc > m_fail);
`ifdef ALU_BIST_MISR_EN
        sx = m_sig[nc];
`else
        sx = 32'h0;
`endif
        if (le == 0) bcnt = 0;
        if (busy) bcnt++;
        chk("busy", 64'(busy), 64'(bx));
        chk("done", 64'(done), 64'(!bx));
        chk("pass", 64'(pass), 64'(!fx));
        chk("op1", 64'(op1), 64'(m_op1[v]));
        chk("op2", 64'(op2), 64'(m_op2[v]));
        chk("ctl", 64'(ctl), 64'(m_ctl[v]));
        chk("fop", 64'(fop), fx ? 64'(m_ctl[m_fail]) : 64'd0);
        chk("fidx", 64'(fidx), fx ? 64'(m_fail % VPO) : 64'd0);
        chk("fexp", 64'(fexp), fx ? 64'(m_fexp) : 64'd0);
        chk("fact", 64'(fact), fx ? 64'(m_fact) : 64'd0);
        chk("sig", 64'(sig), 64'(sx));
        if (le == 0) begin
            chk("v0_op1_lit", 64'(op1), 64'h0000_0000_ACE1_2468);
            chk("v0_op2_lit", 64'(op2), 64'h0000_0000_5670_9234);
        end
        if (le == 2) chk("v1_op1_lit", 64'(op1), 64'h0000_0000_2B38_491A);
        if (le == 2 * VPO) chk("or_ctl_lit", 64'(ctl), 64'(C_OR));
    endtask

    task automatic post_checks(input int pc);
        int sd;
        chk("post_done", 64'(done), 64'd1);
        chk("post_busy_cycles", 64'(bcnt), 64'(RUN));
        case (pc)
            1, 4, 5: begin
                chk("good_pass", 64'(pass), 64'd1);
                chk("good_fop", 64'(fop), 64'd0);
                chk("good_fidx", 64'(fidx), 64'd0);
                chk("good_fexp", 64'(fexp), 64'd0);
`ifdef ALU_BIST_MISR_EN
                if (pc == 1) begin
                    chk("sig_nonzero", 64'(sig != 32'h0), 64'd1);
                    good_sig = sig;
                end else begin
                    chk("sig_repeat", 64'(sig), 64'(good_sig));
                end
`else
                chk("sig_off", 64'(sig), 64'd0);
`endif
            end
            2: begin
                chk("add_pass", 64'(pass), 64'd0);
                chk("add_fop", 64'(fop), 64'(C_ADD));
                chk("add_fidx", 64'(fidx), 64'd0);
                chk("add_bit0", 64'((fexp ^ fact) & 33'h1), 64'd1);
`ifdef ALU_BIST_MISR_EN
                chk("sig_fault_differs", 64'(sig != good_sig), 64'd1);
`endif
            end
            3: begin
                sd = -1;
                for (int v = 4 * VPO; v < 5 * VPO; v++)
                    if (sd < 0 && m_op1[v][31] != m_op2[v][31])
                        sd = v - 4 * VPO;
                chk("solt_pass", 64'(pass), 64'd0);
                chk("solt_fop", 64'(fop), 64'(C_SOLT));
                chk("solt_fidx", 64'(fidx), 64'(sd));
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Single compare process
    always @(negedge clk) begin
        if (zchk) chk_zero("zero");
        if (track) check_cycle();
        if (post != 0) post_checks(post);
    end

    task automatic do_start(input bit h);
        @(negedge clk);
        start = 1'b1;
        hold  = h;
        t0    = cyc;
        track = 1'b1;
        @(negedge clk);
        if (!h) start = 1'b0;
    endtask

    task automatic do_run(input bit h, input int pc);
        do_start(h);
        repeat (h ? 2 * RUN + 1 : RUN + 2) @(negedge clk);
        track = 1'b0;
        start = 1'b0;
        #1 post = pc;
        @(negedge clk);
        #1 post = 0;
    endtask

    initial begin
        zchk = 1'b1;
        @(negedge clk);
        #1 zchk = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1 zchk = 1'b1;
        @(negedge clk);
        #1 zchk = 1'b0;

        fault_mode = 0;
        build_model();
        do_run(1'b0, 1);

        fault_mode = 1;
        build_model();
        do_run(1'b0, 2);

        fault_mode = 2;
        build_model();
        do_run(1'b0, 3);

        fault_mode = 0;
        build_model();
        do_run(1'b1, 4);

        do_start(1'b0);
        repeat (50) @(negedge clk);
        track = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        zchk = 1'b1;
        @(negedge clk);
        #1 zchk = 1'b0;
        rst_n = 1'b1;
        do_run(1'b0, 5);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test sequencer for the datapath ALU. It drives the ALU's operand and control inputs and checks the result and zero-flag outputs against an internal golden model. Operands come from an LFSR, and every operation code is swept: AND, OR, ADD, SUB, SOLT, NOR. It sits beside the `alu` instance in the CPU datapath, muxed onto the ALU inputs in test mode, and reports pass/fail plus the first failing vector.

## Interface
Parameters:
- `VECTORS_PER_OP`, default 32: vectors per operation; legal range 1..256.
- `LFSR_SEED`, default 32'hACE1_2468: LFSR seed; a value of 0 is replaced by 32'h1.
- `OPERAND_MASK`, default 32'hFFFF_FFFF: ANDed onto each generated operand.

Ports:
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_start` in 1: start request, sampled only in IDLE or DONE.
- `o_busy` out 1: high while vectors are being run.
- `o_done` out 1: high from run completion until the next start.
- `o_pass` out 1: valid while `o_done`; 1 means no mismatch occurred.
- `o_alu_op1` out 32: operand 1 to the ALU `i_op1`; registered.
- `o_alu_op2` out 32: operand 2 to the ALU `i_op2`; registered.
- `o_alu_control` out 4: operation code to the ALU `i_control`, using the `ALU_*` codes from MIPS_Parameters.vh; registered.
- `i_alu_result` in 32: ALU `o_result`.
- `i_alu_zf` in 1: ALU `o_zf`.
- `o_fail_op` out 4: control code of the first mismatch.
- `o_fail_idx` out 8: vector index (within its operation) of the first mismatch.
- `o_fail_expected` out 33: {expected zf, expected result} of the first mismatch.
- `o_fail_actual` out 33: {zf, result} as sampled at the first mismatch.
- `o_signature` out 32: MISR signature (see Configuration).

## Operation
State machine: IDLE, DRIVE, CHECK, DONE.

IDLE/DONE, on `i_start`=1:
- Reload the LFSR from the seed.
- Clear all fail fields, set `o_pass`=1, clear the signature.
- Load vector 0 of `ALU_AND`.
- Set `o_busy`=1, `o_done`=0, go to DRIVE.

DRIVE:
- Operands are held stable for one settle cycle, then go to CHECK.

CHECK (compare edge):
- Sample `i_alu_result` and `i_alu_zf` and compare them with the expected values.
- On the first mismatch only: capture the fail fields and clear `o_pass`. Later mismatches are ignored; the run always completes.
- If more vectors remain, load the next vector and go to DRIVE.
- Otherwise go to DONE with `o_busy`=0 and `o_done`=1. The operand and control outputs hold their last vector.

Vector generation:
- `o_alu_op1` = L & `OPERAND_MASK` and `o_alu_op2` = step(L) & `OPERAND_MASK`, where L is the current LFSR state.
- The LFSR then advances by step(step(L)).
- step is a 32-bit Galois LFSR: shift right; if the old bit 0 was 1, XOR with 32'h8020_0003.

Operation order: `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SOLT`, `ALU_NOR`, with `VECTORS_PER_OP` vectors each.

Golden model:
- AND, OR and NOR are bitwise.
- ADD and SUB are modulo 2^32, with no carry or overflow checked.
- SOLT gives 32'd1 if $signed(op1) < $signed(op2), else 32'd0.
- The expected zf is (expected result == 0).

Start handling:
- `i_start` is ignored while busy.
- `i_start` in DONE restarts the run. Runs are deterministic.

## Timing
- Reset values: every output is 0, including `o_pass`, `o_alu_control` and `o_signature`; state is IDLE.
- Reset mid-run forces these values immediately (asynchronous) and abandons the run.
- Each vector takes 2 cycles, and the ALU result has 2 full cycles to settle before sampling.
- Taking the start edge as edge 0, `o_busy` rises after edge 0.
- `o_done` rises after edge 2·6·`VECTORS_PER_OP`, which is edge 384 with defaults.
- Fail fields and `o_pass` update on the same compare edge as the mismatch.

## Configuration
- `ALU_BIST_MISR_EN` defined:
  - A 32-bit MISR updates on every compare edge: S ← step(S) ^ i_alu_result ^ {31'b0, i_alu_zf}.
  - S is cleared at start and `o_signature` = S.
- `ALU_BIST_MISR_EN` undefined: no MISR logic; `o_signature` is tied to 32'h0.

## Test plan
- Reset, then pulse `i_start` with a correct behavioural ALU attached -> `o_busy` high for exactly 384 cycles; `o_done`=1, `o_pass`=1, all fail fields 0.
- Bench ALU flips result bit 0 for `ALU_ADD` only -> `o_pass`=0, `o_fail_op`=`ALU_ADD`, `o_fail_idx`=0, `o_fail_expected`^`o_fail_actual` has bit 0 set; `o_done` still at edge 384.
- Bench ALU computes SOLT as an unsigned compare -> `o_fail_op`=`ALU_SOLT`, and `o_fail_idx` is the first index where the operand signs differ; AND/OR/ADD/SUB vectors pass.
- Hold `i_start`=1 throughout -> first run unaffected (done at edge 384). Second run starts on the edge after done, has identical operand sequence, and identical `o_signature` when the MISR is enabled.
- Assert `i_rst_n`=0 at cycle 50 of a run -> all outputs 0 at once. Release, then start -> full 384-cycle run with `o_pass`=1.
- With `ALU_BIST_MISR_EN` defined, a correct ALU -> `o_signature` is nonzero and equal across runs, and changes under a single-bit fault. Without the macro -> 32'h0.
